squash_data_que: RTL

//  Circular allocate-by-index buffer for the dispatch/commit path (ROB, branch buf, imm buf).

---
 rtl/squash_data_que.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/squash_data_que.sv
// Circular allocate-by-index queue: compacted multi-port enqueue, out-of-order completion marks,
// in-order retire of up to COMMIT_WID entries per cycle, and tail rollback on squash.
// Optional performance counters are enabled by defining SQUASH_DATA_QUE_PERF_EN.
`ifndef XDEF
`define XDEF 31:0
`endif

module squash_data_que #(
    parameter int DEPTH         = 30,
    parameter int INPORT_NUM    = 4,
    parameter int READPORT_NUM  = 4,
    parameter int CLEARPORT_NUM = 4,
    parameter int COMMIT_WID    = 4,
    localparam int IW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_stall,
    output logic                                 o_empty,
    output logic [CW-1:0]                        o_count,
    output logic                                 o_can_enq,
    input  logic                                 i_enq_vld,
    input  logic [INPORT_NUM-1:0]                i_enq_req,
    input  logic [INPORT_NUM-1:0]                i_enq_mark_fin,
    input  logic [INPORT_NUM-1:0][`XDEF]         i_enq_data,
    output logic [INPORT_NUM-1:0][IW-1:0]        o_alloc_idx,
    output logic [INPORT_NUM-1:0]                o_alloc_flip,
    input  logic [READPORT_NUM-1:0][IW-1:0]      i_read_idx,
    output logic [READPORT_NUM-1:0][`XDEF]       o_read_data,
    input  logic [CLEARPORT_NUM-1:0]             i_clear_vld,
    input  logic [CLEARPORT_NUM-1:0][IW-1:0]     i_clear_idx,
    input  logic                                 i_squash_vld,
    input  logic [IW-1:0]                        i_squash_idx,
    input  logic                                 i_squash_flip,
    output logic [COMMIT_WID-1:0]                o_commit_vld,
    output logic [COMMIT_WID-1:0][IW-1:0]        o_commit_idx,
    output logic [COMMIT_WID-1:0][`XDEF]         o_commit_data
`ifdef SQUASH_DATA_QUE_PERF_EN
    ,
    output logic [31:0]                          o_full_cycles,
    output logic [31:0]                          o_squash_cnt
`endif
);

    typedef logic [`XDEF] dtype;
    localparam logic [IW+1:0] DEPTH_W = (IW + 2)'(DEPTH);

    // Returns {wrapped, (p + n) mod DEPTH}; n never exceeds DEPTH.
    function automatic logic [IW:0] wrap_add(input logic [IW-1:0] p, input logic [IW:0] n);
        logic [IW+1:0] s;
        s = {2'b00, p} + {1'b0, n};
        if (s >= DEPTH_W) return {1'b1, IW'(s - DEPTH_W)};
        return {1'b0, IW'(s)};
    endfunction

    dtype             mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d, fin_q, fin_d;
    logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
    logic             head_flip_q, head_flip_d, tail_flip_q, tail_flip_d;
    logic [CW-1:0]    count_q, count_d;

    logic [IW:0] enq_n, alloc_sum, retire_m, commit_sum, head_sum, tail_sum;
    logic        enq_fire, run;
    int          sq_count, sq_len;

    // NOTE: always_comb uses blocking '=' so later statements see earlier results; every output
    // gets a value before any conditional path, which keeps the block free of inferred latches.
    always_comb begin
        enq_n     = '0;
        alloc_sum = '0;
        for (int k = 0; k < INPORT_NUM; k++) begin
            alloc_sum       = wrap_add(tail_q, enq_n);
            o_alloc_idx[k]  = alloc_sum[IW-1:0];
            o_alloc_flip[k] = tail_flip_q ^ alloc_sum[IW];
            enq_n           = enq_n + (IW + 1)'(i_enq_req[k]);
        end
    end

    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_can_enq = (int'(enq_n) <= DEPTH - int'(count_q)) && !i_squash_vld;
    assign enq_fire  = i_enq_vld && o_can_enq;

    always_comb begin
        for (int r = 0; r < READPORT_NUM; r++) o_read_data[r] = mem_q[i_read_idx[r]];
    end

    // Retire is a prefix: one unfinished entry stops everything younger.
    always_comb begin
        run        = !i_stall && !i_squash_vld;
        retire_m   = '0;
        commit_sum = '0;
        for (int k = 0; k < COMMIT_WID; k++) begin
            commit_sum       = wrap_add(head_q, (IW + 1)'(k));
            o_commit_idx[k]  = commit_sum[IW-1:0];
            o_commit_data[k] = mem_q[commit_sum[IW-1:0]];
            run              = run && fin_q[commit_sum[IW-1:0]] && (k < int'(count_q));
            o_commit_vld[k]  = run;
            retire_m         = retire_m + (IW + 1)'(run);
        end
    end

    assign sq_count = int'(i_squash_idx) - int'(head_q) + ((i_squash_flip != head_flip_q) ? DEPTH : 0);
    assign sq_len   = int'(tail_q) - int'(i_squash_idx) + ((i_squash_flip != tail_flip_q) ? DEPTH : 0);

    always_comb begin
        vld_d       = vld_q;
        fin_d       = fin_q;
        head_d      = head_q;
        head_flip_d = head_flip_q;
        tail_d      = tail_q;
        tail_flip_d = tail_flip_q;
        head_sum    = wrap_add(head_q, retire_m);
        tail_sum    = wrap_add(tail_q, enq_fire ? enq_n : '0);
        count_d     = CW'(int'(count_q) + (enq_fire ? int'(enq_n) : 0) - int'(retire_m));

        for (int c = 0; c < CLEARPORT_NUM; c++)
            if (i_clear_vld[c]) fin_d[i_clear_idx[c]] = 1'b1;

        for (int k = 0; k < COMMIT_WID; k++) begin
            if (o_commit_vld[k]) begin
                vld_d[o_commit_idx[k]] = 1'b0;
                fin_d[o_commit_idx[k]] = 1'b0;
            end
        end
        head_d      = head_sum[IW-1:0];
        head_flip_d = head_flip_q ^ head_sum[IW];

        if (enq_fire) begin
            for (int k = 0; k < INPORT_NUM; k++) begin
                if (i_enq_req[k]) begin
                    vld_d[o_alloc_idx[k]] = 1'b1;
                    fin_d[o_alloc_idx[k]] = i_enq_mark_fin[k];
                end
            end
            tail_d      = tail_sum[IW-1:0];
            tail_flip_d = tail_flip_q ^ tail_sum[IW];
        end

        // Squash comes last so that same-cycle clears to discarded entries are dropped.
        if (i_squash_vld) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (((i >= int'(i_squash_idx)) ? i - int'(i_squash_idx)
                                               : i + DEPTH - int'(i_squash_idx)) < sq_len) begin
                    vld_d[i] = 1'b0;
                    fin_d[i] = 1'b0;
                end
            end
            tail_d      = i_squash_idx;
            tail_flip_d = i_squash_flip;
            count_d     = CW'(sq_count);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            fin_q       <= '0;
            head_q      <= '0;
            head_flip_q <= 1'b0;
            tail_q      <= '0;
            tail_flip_q <= 1'b0;
            count_q     <= '0;
        end else begin
            vld_q       <= vld_d;
            fin_q       <= fin_d;
            head_q      <= head_d;
            head_flip_q <= head_flip_d;
            tail_q      <= tail_d;
            tail_flip_q <= tail_flip_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the payload array has no reset; vld/fin already say which slots hold meaningful data.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int k = 0; k < INPORT_NUM; k++)
                if (i_enq_req[k]) mem_q[o_alloc_idx[k]] <= i_enq_data[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CLEARPORT_NUM; c++)
                if (i_clear_vld[c])
                    assert (vld_q[i_clear_idx[c]]) else $fatal(1, "clear of an entry that is not valid");
            if (i_squash_vld)
                assert (sq_count >= 0 && sq_count <= int'(count_q)) else $fatal(1, "squash target outside [head, tail]");
        end
    end

`ifdef SQUASH_DATA_QUE_PERF_EN
    logic [31:0] full_cycles_q, full_cycles_d, squash_cnt_q, squash_cnt_d;

    always_comb begin
        full_cycles_d = full_cycles_q;
        squash_cnt_d  = squash_cnt_q;
        if (int'(count_q) == DEPTH && full_cycles_q != '1) full_cycles_d = full_cycles_q + 32'd1;
        if (i_squash_vld && squash_cnt_q != '1) squash_cnt_d = squash_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles_q <= '0;
            squash_cnt_q  <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    assign o_full_cycles = full_cycles_q;
    assign o_squash_cnt  = squash_cnt_q;
`endif

endmodule
